// File: rtl/matrix_stream_ctrl_pkg.sv
// Shared constants and FSM encoding for the matrix streaming controller.
// Matrix storage is built from the same constants, so the element width and
// index widths always agree between the storage and this controller.
package matrix_stream_ctrl_pkg;

    localparam int MAX_DIM    = 5;  // largest row/column count
    localparam int ELEM_WIDTH = 8;  // element width in bits
    localparam int DIM_BITS   = 3;  // row/column index width
    localparam int RD_TIMEOUT = 4;  // WAIT cycles allowed before error
    localparam int DIM_PORT_W = 4;  // width of the m/n dimension ports

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_SEND  = 3'd4
    } state_t;

    // A dimension is usable when it is in 1..max_d.
    function automatic logic dim_in_range(input logic [DIM_PORT_W-1:0] d,
                                          input logic [DIM_PORT_W-1:0] max_d);
        return (d != '0) && (d <= max_d);
    endfunction

endpackage

// File: rtl/matrix_stream_ctrl_index_counter.sv
// matrix_index_counter: row/column walker for a row-major matrix stream.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   i_clear              restart at row 0, column 0
//   i_advance            step to the next element (column wraps at i_last_col)
//   i_last_row/col       m-1 and n-1 of the matrix being walked
//   o_row, o_col         current element address
//   o_last_col, o_last   current element is in column n-1 / is the final one
module matrix_index_counter #(
    parameter int DIM_BITS = matrix_stream_ctrl_pkg::DIM_BITS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_clear,
    input  logic                i_advance,
    input  logic [DIM_BITS-1:0] i_last_row,
    input  logic [DIM_BITS-1:0] i_last_col,
    output logic [DIM_BITS-1:0] o_row,
    output logic [DIM_BITS-1:0] o_col,
    output logic                o_last_col,
    output logic                o_last
);
    import matrix_stream_ctrl_pkg::*;

    logic [DIM_BITS-1:0] r_row;
    logic [DIM_BITS-1:0] r_col;

    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_clear) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_advance) begin
            // The caller never advances past the final element, so the row
            // index cannot run beyond m-1.
            if (r_col == i_last_col) begin
                r_col <= '0;
                r_row <= r_row + DIM_BITS'(1);
            end else begin
                r_col <= r_col + DIM_BITS'(1);
            end
        end
    end

    assign o_row      = r_row;
    assign o_col      = r_col;
    assign o_last_col = (r_col == i_last_col);
    assign o_last     = o_last_col && (r_row == i_last_row);

endmodule

// File: rtl/matrix_stream_ctrl.sv
// matrix_stream_ctrl: reads one stored m x n matrix element by element from
// storage and streams it out over a valid/ready interface, row-major.
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   start, m, n, slot_idx       stream request and matrix selection
//   busy, done, err             status: not idle / end-of-stream / failure pulses
//   query_*                     storage occupancy query for the latched m x n
//   rd_*                        storage read request (rd_en) and response
//   out_*                       output stream with last-column / last flags
module matrix_stream_ctrl #(
    parameter int MAX_DIM    = matrix_stream_ctrl_pkg::MAX_DIM,
    parameter int ELEM_WIDTH = matrix_stream_ctrl_pkg::ELEM_WIDTH,
    parameter int DIM_BITS   = matrix_stream_ctrl_pkg::DIM_BITS,
    parameter int RD_TIMEOUT = matrix_stream_ctrl_pkg::RD_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [3:0]            m,
    input  logic [3:0]            n,
    input  logic                  slot_idx,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [3:0]            query_m,
    output logic [3:0]            query_n,
    input  logic                  query_slot0_valid,
    input  logic                  query_slot1_valid,
    output logic                  rd_en,
    output logic [3:0]            rd_m,
    output logic [3:0]            rd_n,
    output logic                  rd_slot_idx,
    output logic [DIM_BITS-1:0]   rd_row_idx,
    output logic [DIM_BITS-1:0]   rd_col_idx,
    input  logic [ELEM_WIDTH-1:0] rd_elem,
    input  logic                  rd_elem_valid,
    output logic [ELEM_WIDTH-1:0] out_elem,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last_col,
    output logic                  out_last
);
    import matrix_stream_ctrl_pkg::*;

    localparam int TMO_W = $clog2(RD_TIMEOUT + 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [3:0]            r_m;
    logic [3:0]            r_n;
    logic                  r_slot;
    logic [ELEM_WIDTH-1:0] r_out_elem;
    logic                  r_done;
    logic                  r_err;
    logic [TMO_W-1:0]      r_tmo;

    logic                  w_accept;
    logic                  w_capture;
    logic                  w_advance;
    logic                  w_set_done;
    logic                  w_set_err;
    logic                  w_slot_valid;
    logic                  w_tmo_expired;
    logic                  w_dims_ok;
    logic [DIM_BITS-1:0]   w_row;
    logic [DIM_BITS-1:0]   w_col;
    logic [DIM_BITS-1:0]   w_last_row;
    logic [DIM_BITS-1:0]   w_last_col_idx;
    logic                  w_at_last_col;
    logic                  w_at_last;

    assign w_dims_ok      = dim_in_range(m, 4'(MAX_DIM)) && dim_in_range(n, 4'(MAX_DIM));
    assign w_slot_valid   = r_slot ? query_slot1_valid : query_slot0_valid;
    assign w_tmo_expired  = (r_tmo == TMO_W'(RD_TIMEOUT - 1));
    assign w_last_row     = DIM_BITS'(r_m - 4'd1);
    assign w_last_col_idx = DIM_BITS'(r_n - 4'd1);

    matrix_index_counter #(
        .DIM_BITS (DIM_BITS)
    ) u_index (
        .clk        (clk),
        .rst_n      (rst),
        .i_clear    (w_accept),
        .i_advance  (w_advance),
        .i_last_row (w_last_row),
        .i_last_col (w_last_col_idx),
        .o_row      (w_row),
        .o_col      (w_col),
        .o_last_col (w_at_last_col),
        .o_last     (w_at_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    // NOTE: defaults first so every path assigns every signal; a missed branch would infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_advance   = 1'b0;
        w_set_done  = 1'b0;
        w_set_err   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (w_dims_ok) begin
                        w_accept    = 1'b1;
                        w_state_nxt = ST_CHECK;
                    end else begin
                        w_set_err = 1'b1;
                    end
                end
            end
            ST_CHECK: begin
                if (w_slot_valid) begin
                    w_state_nxt = ST_ISSUE;
                end else begin
                    w_set_err   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            // One cycle of rd_en per element gives storage a fresh rising edge.
            ST_ISSUE: w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (rd_elem_valid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_SEND;
                end else if (w_tmo_expired) begin
                    w_set_err   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (out_ready) begin
                    if (w_at_last) begin
                        w_set_done  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_advance   = 1'b1;
                        w_state_nxt = ST_ISSUE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_m        <= '0;
            r_n        <= '0;
            r_slot     <= 1'b0;
            r_out_elem <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_tmo      <= '0;
        end else begin
            r_done <= w_set_done;
            r_err  <= w_set_err;
            if (w_accept) begin
                r_m    <= m;
                r_n    <= n;
                r_slot <= slot_idx;
            end
            // Captured only in WAIT, so the element is stable for all of SEND.
            if (w_capture) r_out_elem <= rd_elem;
            if (r_state == ST_WAIT) r_tmo <= r_tmo + TMO_W'(1);
            else                    r_tmo <= '0;
        end
    end

    assign busy         = (r_state != ST_IDLE);
    assign done         = r_done;
    assign err          = r_err;
    assign query_m      = r_m;
    assign query_n      = r_n;
    assign rd_m         = r_m;
    assign rd_n         = r_n;
    assign rd_slot_idx  = r_slot;
    assign rd_en        = (r_state == ST_ISSUE);
    assign rd_row_idx   = w_row;
    assign rd_col_idx   = w_col;
    assign out_elem     = r_out_elem;
    assign out_valid    = (r_state == ST_SEND);
    // Flags are qualified with out_valid so they read 0 outside SEND.
    assign out_last_col = out_valid && w_at_last_col;
    assign out_last     = out_valid && w_at_last;

endmodule

// File: tb/tb_matrix_stream_ctrl.sv
// Directed testbench for matrix_stream_ctrl with a behavioural matrix storage.
// Tick t is the falling edge after the t-th rising edge following a start.
module tb_matrix_stream_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] m;
    logic [3:0] n;
    logic       slot_idx;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] query_m;
    logic [3:0] query_n;
    logic       query_slot0_valid;
    logic       query_slot1_valid;
    logic       rd_en;
    logic [3:0] rd_m;
    logic [3:0] rd_n;
    logic       rd_slot_idx;
    logic [2:0] rd_row_idx;
    logic [2:0] rd_col_idx;
    logic [7:0] rd_elem;
    logic       rd_elem_valid;
    logic [7:0] out_elem;
    logic       out_valid;
    logic       out_ready;
    logic       out_last_col;
    logic       out_last;

    int vectors;
    int miscompares;

    matrix_stream_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .m                 (m),
        .n                 (n),
        .slot_idx          (slot_idx),
        .busy              (busy),
        .done              (done),
        .err               (err),
        .query_m           (query_m),
        .query_n           (query_n),
        .query_slot0_valid (query_slot0_valid),
        .query_slot1_valid (query_slot1_valid),
        .rd_en             (rd_en),
        .rd_m              (rd_m),
        .rd_n              (rd_n),
        .rd_slot_idx       (rd_slot_idx),
        .rd_row_idx        (rd_row_idx),
        .rd_col_idx        (rd_col_idx),
        .rd_elem           (rd_elem),
        .rd_elem_valid     (rd_elem_valid),
        .out_elem          (out_elem),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_last_col      (out_last_col),
        .out_last          (out_last)
    );

    logic [37:0] all_outs;
    assign all_outs = {busy, done, err, query_m, query_n, rd_en, rd_m, rd_n, rd_slot_idx,
                       rd_row_idx, rd_col_idx, out_elem, out_valid, out_last_col, out_last};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Storage model: responds one cycle after each rd_en rising edge.
    logic [7:0] mem [2][5][5];
    int   rd_edges;
    int   drop_read;
    logic mdl_fire;
    logic prev_rd_en;
    int   mdl_s, mdl_r, mdl_c;

    initial begin
        rd_elem_valid = 1'b0;
        rd_elem       = '0;
        prev_rd_en    = 1'b0;
        rd_edges      = 0;
        forever begin
            @(negedge clk);
            mdl_fire   = rst && rd_en && !prev_rd_en;
            prev_rd_en = rst && rd_en;
            mdl_s      = int'(rd_slot_idx);
            mdl_r      = int'(rd_row_idx);
            mdl_c      = int'(rd_col_idx);
            @(posedge clk);
            #1;
            if (mdl_fire && rst) begin
                rd_edges++;
                if (rd_edges == drop_read) begin
                    rd_elem_valid = 1'b0;
                end else begin
                    rd_elem       = mem[mdl_s][mdl_r][mdl_c];
                    rd_elem_valid = 1'b1;
                end
            end else begin
                rd_elem_valid = 1'b0;
            end
        end
    end

    // Observation record filled by run_stream.
    int   got_elem[$];
    logic got_lc[$];
    logic got_last[$];
    int   got_tick[$];
    int   got_rd[$];
    int   stall_vals[$];
    int   done_tick, err_tick, both_cnt, busy_seen;
    int   rd_base;

    task automatic kick(input logic [3:0] mm, input logic [3:0] nn, input logic s);
        @(negedge clk);
        m        = mm;
        n        = nn;
        slot_idx = s;
        start    = 1'b1;
        rd_base  = rd_edges;
    endtask

    // Runs ticks after a kick, recording handshakes and pulses. Element
    // stall_elem (1-based) is held off for stall_cycles; at poke_tick a
    // stray start with other dimensions is driven.
    task automatic run_stream(input int budget, input int stall_elem,
                              input int stall_cycles, input int poke_tick);
        int stall_left;
        stall_left = stall_cycles;
        got_elem.delete(); got_lc.delete(); got_last.delete();
        got_tick.delete(); got_rd.delete(); stall_vals.delete();
        done_tick = -1; err_tick = -1; both_cnt = 0; busy_seen = 0;
        for (int t = 1; t <= budget; t++) begin
            @(negedge clk);
            start = (t == poke_tick);
            if (t == poke_tick) begin
                m = 4'd1;
                n = 4'd1;
            end
            if (busy) busy_seen++;
            if (done && err) both_cnt++;
            if (err && err_tick < 0) err_tick = t;
            if (done && done_tick < 0) done_tick = t;
            out_ready = 1'b1;
            if (out_valid && got_elem.size() == stall_elem - 1 && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
                stall_vals.push_back(int'(out_elem));
            end
            if (out_valid && out_ready) begin
                got_elem.push_back(int'(out_elem));
                got_lc.push_back(out_last_col);
                got_last.push_back(out_last);
                got_tick.push_back(t);
                got_rd.push_back(rd_edges - rd_base);
            end
            if (done_tick >= 0 || err_tick >= 0) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (all_outs !== '0) begin
            $display("FAIL reset_outputs: got %h expected 0", all_outs);
            miscompares++;
        end
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            $display("FAIL reset_release_busy: got %b expected 0", busy);
            miscompares++;
        end
    endtask

    task automatic test_stream_2x3();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 3; c++) mem[0][r][c] = 8'(r * 3 + c + 1);
        query_slot0_valid = 1'b1;
        kick(4'd2, 4'd3, 1'b0);
        run_stream(40, 0, 0, 7);
        vectors++;
        if (got_elem.size() != 6) begin
            $display("FAIL s23_count: got %0d expected 6", got_elem.size());
            miscompares++;
        end
        for (int k = 0; k < got_elem.size() && k < 6; k++) begin
            vectors++;
            if (got_elem[k] != k + 1 || got_lc[k] !== (k == 2 || k == 5) ||
                got_last[k] !== (k == 5) || got_tick[k] != 3 * (k + 1) + 1 ||
                got_rd[k] != k + 1) begin
                $display("FAIL s23_elem%0d: got elem %0d lc %b last %b tick %0d reads %0d expected %0d %b %b %0d %0d",
                         k, got_elem[k], got_lc[k], got_last[k], got_tick[k], got_rd[k],
                         k + 1, (k == 2 || k == 5), (k == 5), 3 * (k + 1) + 1, k + 1);
                miscompares++;
            end
        end
        vectors++;
        if (done_tick != 20 || err_tick != -1 || both_cnt != 0) begin
            $display("FAIL s23_done: got done tick %0d err tick %0d both %0d expected 20 -1 0",
                     done_tick, err_tick, both_cnt);
            miscompares++;
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL s23_after: got done %b busy %b expected 0 0", done, busy);
            miscompares++;
        end
    endtask

    task automatic test_single_1x1();
        mem[1][0][0] = 8'hA5;
        query_slot1_valid = 1'b1;
        kick(4'd1, 4'd1, 1'b1);
        run_stream(12, 0, 0, 0);
        vectors++;
        if (got_elem.size() != 1 || done_tick != 5) begin
            $display("FAIL s11_timing: got count %0d done tick %0d expected 1 5",
                     got_elem.size(), done_tick);
            miscompares++;
        end else begin
            vectors++;
            if (got_elem[0] != 'hA5 || got_lc[0] !== 1'b1 || got_last[0] !== 1'b1) begin
                $display("FAIL s11_elem: got %0h lc %b last %b expected a5 1 1",
                         got_elem[0], got_lc[0], got_last[0]);
                miscompares++;
            end
        end
    endtask

    task automatic test_max_row();
        for (int c = 0; c < 5; c++) mem[0][0][c] = 8'(11 + c);
        query_slot0_valid = 1'b1;
        kick(4'd1, 4'd5, 1'b0);
        run_stream(30, 0, 0, 0);
        vectors++;
        if (got_elem.size() != 5 || done_tick != 17) begin
            $display("FAIL s15_timing: got count %0d done tick %0d expected 5 17",
                     got_elem.size(), done_tick);
            miscompares++;
        end
        for (int k = 0; k < got_elem.size() && k < 5; k++) begin
            vectors++;
            if (got_elem[k] != 11 + k || got_lc[k] !== (k == 4) || got_last[k] !== (k == 4)) begin
                $display("FAIL s15_elem%0d: got %0d lc %b last %b expected %0d %b %b",
                         k, got_elem[k], got_lc[k], got_last[k], 11 + k, (k == 4), (k == 4));
                miscompares++;
            end
        end
    endtask

    task automatic test_bad_dims();
        logic [7:0] dims [3];
        dims[0] = 8'h62;
        dims[1] = 8'h03;
        dims[2] = 8'h30;
        for (int i = 0; i < 3; i++) begin
            kick(dims[i][7:4], dims[i][3:0], 1'b0);
            run_stream(4, 0, 0, 0);
            vectors++;
            if (err_tick != 1 || busy_seen != 0 || rd_edges != rd_base) begin
                $display("FAIL bad_dims_%0d: got err tick %0d busy cycles %0d reads %0d expected 1 0 0",
                         i, err_tick, busy_seen, rd_edges - rd_base);
                miscompares++;
            end
            @(negedge clk);
            vectors++;
            if (err !== 1'b0 || busy !== 1'b0 || rd_en !== 1'b0) begin
                $display("FAIL bad_dims_after_%0d: got err %b busy %b rd_en %b expected 0 0 0",
                         i, err, busy, rd_en);
                miscompares++;
            end
        end
    endtask

    task automatic test_empty_slot();
        query_slot0_valid = 1'b1;
        query_slot1_valid = 1'b0;
        kick(4'd3, 4'd3, 1'b1);
        run_stream(8, 0, 0, 0);
        vectors++;
        if (err_tick != 2 || busy_seen != 1 || rd_edges != rd_base || done_tick != -1) begin
            $display("FAIL empty_slot: got err tick %0d busy cycles %0d reads %0d done tick %0d expected 2 1 0 -1",
                     err_tick, busy_seen, rd_edges - rd_base, done_tick);
            miscompares++;
        end
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || err !== 1'b0) begin
            $display("FAIL empty_slot_after: got busy %b err %b expected 0 0", busy, err);
            miscompares++;
        end
    endtask

    task automatic test_backpressure();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++) mem[0][r][c] = 8'(r * 2 + c + 1);
        query_slot0_valid = 1'b1;
        kick(4'd2, 4'd2, 1'b0);
        run_stream(40, 2, 5, 0);
        vectors++;
        if (stall_vals.size() != 5 || got_elem.size() != 4 || done_tick != 19) begin
            $display("FAIL bp_shape: got stall cycles %0d count %0d done tick %0d expected 5 4 19",
                     stall_vals.size(), got_elem.size(), done_tick);
            miscompares++;
        end
        for (int i = 0; i < stall_vals.size(); i++) begin
            vectors++;
            if (stall_vals[i] != 2) begin
                $display("FAIL bp_hold%0d: got %0d expected 2", i, stall_vals[i]);
                miscompares++;
            end
        end
        for (int k = 0; k < got_elem.size() && k < 4; k++) begin
            vectors++;
            if (got_elem[k] != k + 1 || got_rd[k] != k + 1) begin
                $display("FAIL bp_elem%0d: got elem %0d reads %0d expected %0d %0d",
                         k, got_elem[k], got_rd[k], k + 1, k + 1);
                miscompares++;
            end
        end
    endtask

    task automatic test_timeout();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++) mem[0][r][c] = 8'(40 + r * 2 + c);
        query_slot0_valid = 1'b1;
        kick(4'd2, 4'd2, 1'b0);
        drop_read = rd_base + 3;
        run_stream(30, 0, 0, 0);
        drop_read = 0;
        // Third read enters WAIT at edge 9; four silent WAIT cycles end at edge 13.
        vectors++;
        if (got_elem.size() != 2 || err_tick != 13 || done_tick != -1 || both_cnt != 0) begin
            $display("FAIL timeout: got count %0d err tick %0d done tick %0d both %0d expected 2 13 -1 0",
                     got_elem.size(), err_tick, done_tick, both_cnt);
            miscompares++;
        end
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || err !== 1'b0) begin
            $display("FAIL timeout_after: got busy %b err %b expected 0 0", busy, err);
            miscompares++;
        end
    endtask

    task automatic test_reset_midstream();
        int late;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) mem[0][r][c] = 8'(r * 3 + c + 1);
        query_slot0_valid = 1'b1;
        kick(4'd3, 4'd3, 1'b0);
        run_stream(6, 0, 0, 0);
        vectors++;
        if (got_elem.size() != 1 || busy !== 1'b1) begin
            $display("FAIL rstmid_pre: got count %0d busy %b expected 1 1", got_elem.size(), busy);
            miscompares++;
        end
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if (all_outs !== '0) begin
            $display("FAIL rstmid_outputs: got %h expected 0", all_outs);
            miscompares++;
        end
        repeat (2) @(negedge clk);
        rst  = 1'b1;
        late = 0;
        repeat (4) begin
            @(negedge clk);
            if (done || err || busy) late++;
        end
        vectors++;
        if (late != 0) begin
            $display("FAIL rstmid_quiet: got %0d active cycles expected 0", late);
            miscompares++;
        end
        kick(4'd3, 4'd3, 1'b0);
        run_stream(40, 0, 0, 0);
        vectors++;
        if (got_elem.size() != 9 || done_tick != 29) begin
            $display("FAIL rstmid_restream: got count %0d done tick %0d expected 9 29",
                     got_elem.size(), done_tick);
            miscompares++;
        end
        for (int k = 0; k < got_elem.size() && k < 9; k++) begin
            vectors++;
            if (got_elem[k] != k + 1) begin
                $display("FAIL rstmid_elem%0d: got %0d expected %0d", k, got_elem[k], k + 1);
                miscompares++;
            end
        end
    endtask

    initial begin
        vectors           = 0;
        miscompares       = 0;
        drop_read         = 0;
        start             = 1'b0;
        m                 = '0;
        n                 = '0;
        slot_idx          = 1'b0;
        out_ready         = 1'b1;
        query_slot0_valid = 1'b0;
        query_slot1_valid = 1'b0;
        for (int s = 0; s < 2; s++)
            for (int r = 0; r < 5; r++)
                for (int c = 0; c < 5; c++) mem[s][r][c] = '0;
        test_reset();
        test_stream_2x3();
        test_single_1x1();
        test_max_row();
        test_bad_dims();
        test_empty_slot();
        test_backpressure();
        test_timeout();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
